// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM sequencer: FSM states,
// half-word select constants, default parameters and address helper.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

    // Half-word select, used as the SRAM address LSB.
    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'd1024;
    localparam int unsigned DEFAULT_WAIT_CYCLES = 2;
    localparam int unsigned DEFAULT_SRAM_AW     = 18;

    // Byte address to data-memory word index; wraps modulo 2^32.
    function automatic logic [31:0] byte_to_word(input logic [31:0] byte_addr,
                                                 input logic [31:0] base);
        return (byte_addr - base) >> 2;
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Wait-state counter for one half-word SRAM phase. Counts 0..WAIT_CYCLES-1
// while enabled, wraps to 0 after the last cycle, and flags that last cycle.
module sram_wait_counter
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       en_i,
    output logic [3:0] count_o,
    output logic       last_o
);

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    logic [3:0] count_q;
    logic [3:0] count_d;

    // Next count: clear has priority, wrap to zero at the end of a phase.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = (count_q == LAST_CNT) ? 4'd0 : count_q + 4'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign last_o  = (count_q == LAST_CNT);

endmodule

// File: rtl/mem_stage_sram_sequencer.sv
// MEM-stage SRAM sequencer: splits each 32-bit load/store into a LO and a HI
// half-word phase on a 16-bit asynchronous SRAM, with programmable wait
// states, and holds the pipeline through `ready` until the access is done.
module mem_stage_sram_sequencer
    import mem_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int unsigned SRAM_AW     = DEFAULT_SRAM_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [31:0]        alu_result,
    input  logic [31:0]        val_rm,
    output logic               ready,
    output logic [31:0]        rdata,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_we_n,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in
);

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    mem_state_e         state_q;
    logic               is_wr_q;
    logic [SRAM_AW-1:0] sram_addr_q;
    logic               sram_we_n_q;
    logic [15:0]        sram_dq_out_q;
    logic               sram_dq_oe_q;
    logic [31:0]        rdata_q;

    logic               req;
    logic [31:0]        word;
    logic [SRAM_AW-1:0] lo_addr;
    logic [SRAM_AW-1:0] hi_addr;
    logic               cnt_clr;
    logic               cnt_en;
    logic [3:0]         cnt;
    logic [3:0]         cnt_next;
    logic               cnt_last;
    logic               unused_word_bits;

    assign req  = mem_r_en | mem_w_en;
    assign word = byte_to_word(alu_result, BASE_ADDR);

    // Out-of-range word indices simply wrap into the SRAM.
    assign lo_addr          = {word[SRAM_AW-2:0], HALF_LO};
    assign hi_addr          = {word[SRAM_AW-2:0], HALF_HI};
    assign unused_word_bits = ^word[31:SRAM_AW-1];

    // The counter only runs inside a half-word phase.
    assign cnt_clr  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign cnt_en   = (state_q == ST_LO) || (state_q == ST_HI);
    assign cnt_next = cnt + 4'd1;

    sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_counter (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .count_o(cnt),
        .last_o (cnt_last)
    );

    // Access FSM with registered SRAM strobes. The write strobe rises one
    // cycle before the phase ends so address and data are held past it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            is_wr_q       <= 1'b0;
            sram_addr_q   <= '0;
            sram_we_n_q   <= 1'b1;
            sram_dq_out_q <= '0;
            sram_dq_oe_q  <= 1'b0;
            rdata_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        state_q       <= ST_LO;
                        is_wr_q       <= mem_w_en;
                        sram_addr_q   <= lo_addr;
                        sram_dq_out_q <= val_rm[15:0];
                        sram_dq_oe_q  <= mem_w_en;
                        sram_we_n_q   <= ~mem_w_en;
                    end
                end
                ST_LO: begin
                    if (cnt_last) begin
                        if (!is_wr_q) begin
                            rdata_q[15:0] <= sram_dq_in;
                        end
                        state_q       <= ST_HI;
                        sram_addr_q   <= hi_addr;
                        sram_dq_out_q <= val_rm[31:16];
                        sram_dq_oe_q  <= is_wr_q;
                        sram_we_n_q   <= ~is_wr_q;
                    end else begin
                        sram_we_n_q <= ~is_wr_q | (cnt_next == LAST_CNT);
                    end
                end
                ST_HI: begin
                    if (cnt_last) begin
                        if (!is_wr_q) begin
                            rdata_q[31:16] <= sram_dq_in;
                        end
                        state_q      <= ST_DONE;
                        sram_we_n_q  <= 1'b1;
                        sram_dq_oe_q <= 1'b0;
                    end else begin
                        sram_we_n_q <= ~is_wr_q | (cnt_next == LAST_CNT);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready       = rst | (state_q == ST_DONE) | ((state_q == ST_IDLE) & ~req);
    assign rdata       = rdata_q;
    assign sram_addr   = sram_addr_q;
    assign sram_we_n   = sram_we_n_q;
    assign sram_dq_out = sram_dq_out_q;
    assign sram_dq_oe  = sram_dq_oe_q;

endmodule

// File: tb/tb_mem_stage_sram_sequencer.sv
// Bench for mem_stage_sram_sequencer: one instance with WAIT_CYCLES=2 and one
// with WAIT_CYCLES=1, each attached to a behavioural 16-bit SRAM.
module tb_mem_stage_sram_sequencer;

    localparam int unsigned AW  = 18;
    localparam int unsigned W_A = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    logic rst;

    // Instance A (WAIT_CYCLES = 2)
    logic          a_r_en, a_w_en, a_ready, a_we_n, a_oe;
    logic [31:0]   a_addr_in, a_wdata, a_rdata;
    logic [AW-1:0] a_addr;
    logic [15:0]   a_dq_out, a_dq_in;

    // Instance B (WAIT_CYCLES = 1)
    logic          b_r_en, b_w_en, b_ready, b_we_n, b_oe;
    logic [31:0]   b_addr_in, b_wdata, b_rdata;
    logic [AW-1:0] b_addr;
    logic [15:0]   b_dq_out, b_dq_in;

    mem_stage_sram_sequencer #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(W_A), .SRAM_AW(AW)) u_dut_a (
        .clk(clk), .rst(rst), .mem_r_en(a_r_en), .mem_w_en(a_w_en),
        .alu_result(a_addr_in), .val_rm(a_wdata), .ready(a_ready), .rdata(a_rdata),
        .sram_addr(a_addr), .sram_we_n(a_we_n), .sram_dq_out(a_dq_out),
        .sram_dq_oe(a_oe), .sram_dq_in(a_dq_in)
    );

    mem_stage_sram_sequencer #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(1), .SRAM_AW(AW)) u_dut_b (
        .clk(clk), .rst(rst), .mem_r_en(b_r_en), .mem_w_en(b_w_en),
        .alu_result(b_addr_in), .val_rm(b_wdata), .ready(b_ready), .rdata(b_rdata),
        .sram_addr(b_addr), .sram_we_n(b_we_n), .sram_dq_out(b_dq_out),
        .sram_dq_oe(b_oe), .sram_dq_in(b_dq_in)
    );

    // SRAM models: write while the strobe is low and the bus is driven.
    logic [15:0]   mem_a [0:(1<<AW)-1];
    logic [15:0]   mem_b [0:(1<<AW)-1];
    logic          pre_en;
    logic [AW-1:0] pre_addr;
    logic [15:0]   pre_data;

    always @(posedge clk) begin
        if (pre_en) mem_a[pre_addr] <= pre_data;
        else if (!a_we_n && a_oe) mem_a[a_addr] <= a_dq_out;
    end
    always @(posedge clk) begin
        if (!b_we_n && b_oe) mem_b[b_addr] <= b_dq_out;
    end
    assign a_dq_in = mem_a[a_addr];
    assign b_dq_in = mem_b[b_addr];

    // Scoreboard for instance A: completion cycle, load data, load flag.
    int unsigned done_q [$];
    logic [31:0] rd_q   [$];
    bit          isrd_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive an access on A and record what it must produce.
    task automatic issue(input bit wr, input bit rd, input logic [31:0] addr,
                         input logic [31:0] data, input int unsigned start,
                         input logic [31:0] exp_rd);
        a_w_en    = wr;
        a_r_en    = rd;
        a_addr_in = addr;
        a_wdata   = data;
        done_q.push_back(start + 2 * W_A + 1);
        rd_q.push_back(exp_rd);
        isrd_q.push_back(rd & ~wr);
    endtask

    // Wait (bounded) for A to complete and compare against the scoreboard.
    task automatic wait_done(input string tag);
        bit          seen;
        bit          we_low;
        int unsigned e_cyc;
        logic [31:0] e_rd;
        bit          e_isrd;
        seen   = 1'b0;
        we_low = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (a_we_n === 1'b0) we_low = 1'b1;
            if (a_ready === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_ready_seen"}, 32'(seen), 32'd1);
        e_cyc  = done_q.pop_front();
        e_rd   = rd_q.pop_front();
        e_isrd = isrd_q.pop_front();
        check({tag, "_latency"}, cyc, e_cyc);
        check({tag, "_done_we_n"}, 32'(a_we_n), 32'd1);
        check({tag, "_done_oe"}, 32'(a_oe), 32'd0);
        if (e_isrd) begin
            check({tag, "_rdata"}, a_rdata, e_rd);
            check({tag, "_read_we_n_high"}, 32'(we_low), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        a_r_en = 0; a_w_en = 0; a_addr_in = 0; a_wdata = 0;
        b_r_en = 0; b_w_en = 0; b_addr_in = 0; b_wdata = 0;
        pre_en = 0; pre_addr = 0; pre_data = 0;

        // Reset state
        @(negedge clk);
        check("rst_ready_forced", 32'(a_ready), 32'd1);
        @(negedge clk);
        check("rst_we_n", 32'(a_we_n), 32'd1);
        check("rst_oe", 32'(a_oe), 32'd0);
        check("rst_addr", 32'(a_addr), 32'd0);
        check("rst_dq_out", 32'(a_dq_out), 32'd0);
        check("rst_rdata", a_rdata, 32'd0);
        rst = 1'b0;

        // Idle for 10 cycles
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle_ready", 32'(a_ready), 32'd1);
            check("idle_we_n", 32'(a_we_n), 32'd1);
            check("idle_oe", 32'(a_oe), 32'd0);
        end

        // Preload half-words 2 and 3
        pre_en = 1; pre_addr = 18'd2; pre_data = 16'h5678;
        @(negedge clk);
        pre_addr = 18'd3; pre_data = 16'h1234;
        @(negedge clk);
        pre_en = 0;

        // Write 0xDEADBEEF to byte address 1024
        issue(1, 0, 32'd1024, 32'hDEADBEEF, cyc, 32'd0);
        #1 check("wr_ready_low_t0", 32'(a_ready), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("wr_addr", 32'(a_addr), (k < 2) ? 32'd0 : 32'd1);
            check("wr_dq_out", 32'(a_dq_out), (k < 2) ? 32'h0000BEEF : 32'h0000DEAD);
            check("wr_we_n", 32'(a_we_n), (k % 2 == 0) ? 32'd0 : 32'd1);
            check("wr_oe", 32'(a_oe), 32'd1);
            check("wr_ready_low", 32'(a_ready), 32'd0);
        end
        wait_done("wr");
        a_w_en = 0;
        @(negedge clk);
        check("wr_mem_lo", 32'(mem_a[0]), 32'h0000BEEF);
        check("wr_mem_hi", 32'(mem_a[1]), 32'h0000DEAD);

        // Read byte address 1028 (half-words 2 and 3)
        issue(0, 1, 32'd1028, 32'd0, cyc, 32'h12345678);
        #1 check("rd_ready_low_t0", 32'(a_ready), 32'd0);
        wait_done("rd");
        a_r_en = 0;
        @(negedge clk);

        // Back-to-back: write then read of the same address
        issue(1, 0, 32'd1040, 32'hCAFEF00D, cyc, 32'd0);
        wait_done("b2b_wr");
        issue(0, 1, 32'd1040, 32'd0, cyc + 1, 32'hCAFEF00D);
        @(negedge clk);
        check("b2b_idle_gap_ready", 32'(a_ready), 32'd0);
        check("b2b_idle_gap_oe", 32'(a_oe), 32'd0);
        wait_done("b2b_rd");
        a_r_en = 0;
        @(negedge clk);

        // Reset two cycles into a write
        a_w_en = 1; a_addr_in = 32'd1048; a_wdata = 32'h11112222;
        @(negedge clk);
        check("rstmid_we_low", 32'(a_we_n), 32'd0);
        @(negedge clk);
        rst = 1; a_w_en = 0;
        @(negedge clk);
        check("rstmid_we_n", 32'(a_we_n), 32'd1);
        check("rstmid_oe", 32'(a_oe), 32'd0);
        check("rstmid_rdata", a_rdata, 32'd0);
        check("rstmid_ready", 32'(a_ready), 32'd1);
        rst = 0;
        @(negedge clk);
        check("rstmid_idle_ready", 32'(a_ready), 32'd1);
        check("rstmid_idle_we_n", 32'(a_we_n), 32'd1);

        // WAIT_CYCLES = 1, both enables high: performed as a write
        b_w_en = 1; b_r_en = 1; b_addr_in = 32'd1036; b_wdata = 32'hA5A55A5A;
        #1 check("w1_ready_low_t0", 32'(b_ready), 32'd0);
        @(negedge clk);
        check("w1_lo_addr", 32'(b_addr), 32'd6);
        check("w1_lo_we_n", 32'(b_we_n), 32'd0);
        check("w1_lo_oe", 32'(b_oe), 32'd1);
        check("w1_lo_dq", 32'(b_dq_out), 32'h00005A5A);
        check("w1_lo_ready", 32'(b_ready), 32'd0);
        @(negedge clk);
        check("w1_hi_addr", 32'(b_addr), 32'd7);
        check("w1_hi_we_n", 32'(b_we_n), 32'd0);
        check("w1_hi_dq", 32'(b_dq_out), 32'h0000A5A5);
        check("w1_hi_ready", 32'(b_ready), 32'd0);
        @(negedge clk);
        check("w1_done_ready", 32'(b_ready), 32'd1);
        check("w1_done_we_n", 32'(b_we_n), 32'd1);
        check("w1_done_oe", 32'(b_oe), 32'd0);
        b_w_en = 0; b_r_en = 0;
        @(negedge clk);
        check("w1_mem_lo", 32'(mem_b[6]), 32'h00005A5A);
        check("w1_mem_hi", 32'(mem_b[7]), 32'h0000A5A5);

        // WAIT_CYCLES = 1 read-back
        b_r_en = 1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("w1_rd_ready", 32'(b_ready), 32'd1);
        check("w1_rd_rdata", b_rdata, 32'hA5A55A5A);
        b_r_en = 0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_sram_sequencer.md
Name: mem_stage_sram_sequencer

Overview:
- Sequences every MEM-stage load/store from the EXE/MEM pipeline register onto an external 16-bit asynchronous SRAM.
- Each 32-bit access is split into two half-word phases, each with programmable wait states.
- Stalls the whole pipeline through `ready`; the hazard/top level drives `freeze = ~ready` into all stage registers.
- Sits between the EXE/MEM register outputs and the MEM/WB register inputs.

Parameters:
- BASE_ADDR, 1024: byte address of data-memory word 0; subtracted from `alu_result`.
- WAIT_CYCLES, 2: cycles per half-word phase; legal range 1..15.
- SRAM_AW, 18: SRAM half-word address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_r_en  in  1  load request from the EXE/MEM register.
- mem_w_en  in  1  store request from the EXE/MEM register.
- alu_result  in  32  byte address.
- val_rm  in  32  store data.
- ready  out  1  access complete, or no access pending; pipeline freezes when 0.
- rdata  out  32  load data to the MEM/WB register.
- sram_addr  out  SRAM_AW  half-word address.
- sram_we_n  out  1  active-low write strobe.
- sram_dq_out  out  16  write data.
- sram_dq_oe  out  1  data-bus output enable; the top level builds the tristate.
- sram_dq_in  in  16  read data from the pad.

Behaviour:
- Reset and clock: single clock domain; reset is synchronous and active-high on `rst`.
- Reset values: state IDLE, counter 0, `sram_addr` 0, `sram_we_n` 1, `sram_dq_oe` 0, `sram_dq_out` 0, `rdata` 0. `ready` is forced to 1 while `rst` is high.
- Address translation:
  - `word = (alu_result - BASE_ADDR) >> 2`, computed modulo 2^32.
  - LO half address = `{word[SRAM_AW-2:0], 1'b0}`; HI half address = `{word[SRAM_AW-2:0], 1'b1}`.
  - Out-of-range addresses wrap silently; no error is raised.
- Request decode: `req = mem_r_en | mem_w_en`. If both are high, the access is performed as a write.
- `ready` (combinational): 1 in IDLE with `req = 0`; 1 in DONE; 0 otherwise.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE: if `req`, latch the operation type, go to LO with counter 0 (`ready` is 0 in this cycle). Otherwise stay in IDLE.
  - LO: `sram_addr` = LO address for WAIT_CYCLES cycles. Counter increments each cycle; at counter = WAIT_CYCLES-1, clear the counter and go to HI.
    - Write: `sram_dq_out = val_rm[15:0]`, `sram_dq_oe = 1`, `sram_we_n = 0` in all cycles of the phase except the last, where it returns to 1. This gives data/address hold time. With WAIT_CYCLES = 1, `sram_we_n` is low for the single cycle.
    - Read: `sram_dq_oe = 0`; `rdata[15:0]` captures `sram_dq_in` in the last phase cycle.
  - HI: same as LO, using the HI address, `val_rm[31:16]` and `rdata[31:16]`.
  - DONE: one cycle with `ready = 1`, `sram_we_n = 1`, `sram_dq_oe = 0`; next state IDLE unconditionally.
- Latency: a request first seen at cycle t gives `ready = 1` at t+2·WAIT_CYCLES+1. Back-to-back accesses have one IDLE cycle between them.
- Input stability: `alu_result`, `val_rm` and the enables are stable while `ready = 0`, because the pipeline is frozen. The block samples `val_rm` and `alu_result` directly each cycle and does not re-latch them.
- `rdata`: holds its last load value and changes only in read phases. It is valid from DONE until the next read.
- Reset mid-access: state returns to IDLE on the next edge, and `sram_we_n`/`sram_dq_oe` are deasserted immediately on that edge. Any partial write is not completed.
- Flush: the block does not observe flush. A flush during an access never occurs, because stage registers are frozen.

Decomposition:
- Shared package `mem_ctrl_pkg`:
  - state enum (IDLE, LO, HI, DONE);
  - HALF_LO/HALF_HI select constants;
  - default BASE_ADDR and WAIT_CYCLES constants.
- One natural sub-module, `sram_wait_counter`:
  - 4-bit counter with clear/enable;
  - `last` output when count = WAIT_CYCLES-1.
- FSM and datapath stay in the top module.

Test Plan:
- Idle: `mem_r_en = mem_w_en = 0` for 10 cycles -> `ready = 1`, `sram_we_n = 1`, `sram_dq_oe = 0` throughout.
- Write (WAIT_CYCLES=2): `mem_w_en = 1`, `alu_result = 1024`, `val_rm = 0xDEADBEEF` at t.
  - `sram_addr` = 0 with `sram_dq_out = 0xBEEF` at t+1..t+2, `sram_we_n` low only at t+1.
  - `sram_addr` = 1 with `sram_dq_out = 0xDEAD` at t+3..t+4, `sram_we_n` low only at t+3.
  - `ready = 1` at t+5.
- Read: SRAM model holds half-word 2 = 0x5678 and 3 = 0x1234; `mem_r_en = 1`, `alu_result = 1028` -> `rdata = 0x12345678` and `ready = 1` at t+5; `sram_we_n` stays 1.
- Back-to-back: write then read of the same address -> read returns the written data; the second access starts the cycle after DONE+IDLE.
- Reset at t+2 of a write -> t+3 is IDLE, `sram_we_n = 1`, `sram_dq_oe = 0`, `rdata = 0`, `ready = 1` when no request.
- Both enables high, WAIT_CYCLES = 1 -> write performed, `ready = 1` at t+3.
